// File: rtl/nn_pkg.sv
// Shared types for the NN layer sequencer: FSM state encoding, error codes
// and the layer index width.
package nn_pkg;

    localparam int LAYER_W = 2;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        REQ_IMG    = 4'd1,
        ACK_IMG    = 4'd2,
        XFER_IMG   = 4'd3,
        REQ_COEF   = 4'd4,
        ACK_COEF   = 4'd5,
        XFER_COEF  = 4'd6,
        START_COMP = 4'd7,
        WAIT_COMP  = 4'd8,
        DONE       = 4'd9,
        ERROR      = 4'd10
    } seq_state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE      = 2'b00;
    localparam err_code_t ERR_IMG_TO    = 2'b01;
    localparam err_code_t ERR_COEF_TO   = 2'b10;
    localparam err_code_t ERR_SPUR_DONE = 2'b11;

endpackage

// File: rtl/nn_layer_sequencer_ack_timer.sv
// Acknowledge watchdog: counts cycles spent waiting for the fetch unit's busy.
// expired flags the cycle whose increment brings the count to ACK_TIMEOUT.
module ack_timer #(
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt_r;

    // Wait-cycle counter; clear dominates enable.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + TO_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = en && (cnt_r == TO_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/nn_layer_sequencer.sv
// Inference sequencer: one image fetch, then per layer a coefficient fetch and
// a compute pass. All outputs are registered from the next-state decode.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_LAYERS  = 3,
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic               abort,
    input  logic               busy,
    input  logic               comp_done,
    output logic               get_image,
    output logic               get_coeffs,
    output logic [LAYER_W-1:0] layer,
    output logic               comp_start,
    output logic               seq_busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code
);

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    seq_state_t         state_r;
    seq_state_t         next_state_s;
    logic [LAYER_W-1:0] next_layer_s;
    err_code_t          next_err_s;
    logic               in_ack_s;
    logic               idle_like_s;
    logic               spur_s;
    logic               timer_expired_s;

    assign in_ack_s    = (state_r == ACK_IMG) || (state_r == ACK_COEF);
    assign idle_like_s = (state_r == IDLE) || (state_r == DONE) || (state_r == ERROR);
    assign spur_s      = comp_done && !idle_like_s && (state_r != WAIT_COMP);

    ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TO_W        (TO_W)
    ) u_ack_timer (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (!in_ack_s),
        .en      (in_ack_s && !busy),
        .expired (timer_expired_s)
    );

    // Next-state, next-layer and error-code selection with abort > spurious > timeout priority.
    always_comb begin
        next_state_s = state_r;
        next_layer_s = layer;
        next_err_s   = err_code;
        if (abort) begin
            next_state_s = IDLE;
            next_layer_s = '0;
            next_err_s   = ERR_NONE;
        end else if (spur_s) begin
            next_state_s = ERROR;
            next_err_s   = ERR_SPUR_DONE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) next_state_s = REQ_IMG;
                    else       next_state_s = IDLE;
                end
                REQ_IMG:  next_state_s = ACK_IMG;
                ACK_IMG: begin
                    if (busy) begin
                        next_state_s = XFER_IMG;
                    end else if (timer_expired_s) begin
                        next_state_s = ERROR;
                        next_err_s   = ERR_IMG_TO;
                    end else begin
                        next_state_s = ACK_IMG;
                    end
                end
                XFER_IMG: begin
                    if (!busy) begin
                        next_state_s = REQ_COEF;
                        next_layer_s = '0;
                    end else begin
                        next_state_s = XFER_IMG;
                    end
                end
                REQ_COEF: next_state_s = ACK_COEF;
                ACK_COEF: begin
                    if (busy) begin
                        next_state_s = XFER_COEF;
                    end else if (timer_expired_s) begin
                        next_state_s = ERROR;
                        next_err_s   = ERR_COEF_TO;
                    end else begin
                        next_state_s = ACK_COEF;
                    end
                end
                XFER_COEF: begin
                    if (!busy) next_state_s = START_COMP;
                    else       next_state_s = XFER_COEF;
                end
                START_COMP: next_state_s = WAIT_COMP;
                WAIT_COMP: begin
                    if (!comp_done) begin
                        next_state_s = WAIT_COMP;
                    end else if (layer == LAST_LAYER) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = REQ_COEF;
                        next_layer_s = layer + LAYER_W'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        next_state_s = REQ_IMG;
                        next_layer_s = '0;
                    end else begin
                        next_state_s = DONE;
                    end
                end
                ERROR: begin
                    if (start) begin
                        next_state_s = REQ_IMG;
                        next_layer_s = '0;
                        next_err_s   = ERR_NONE;
                    end else begin
                        next_state_s = ERROR;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    next_layer_s = '0;
                    next_err_s   = ERR_NONE;
                end
            endcase
        end
    end

    // State register plus outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= IDLE;
            layer      <= '0;
            err_code   <= ERR_NONE;
            get_image  <= 1'b0;
            get_coeffs <= 1'b0;
            comp_start <= 1'b0;
            seq_busy   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            layer      <= next_layer_s;
            err_code   <= next_err_s;
            get_image  <= (next_state_s == REQ_IMG);
            get_coeffs <= (next_state_s == REQ_COEF);
            comp_start <= (next_state_s == START_COMP);
            seq_busy   <= !((next_state_s == IDLE) || (next_state_s == DONE) ||
                            (next_state_s == ERROR));
            done       <= (next_state_s == DONE);
            error      <= (next_state_s == ERROR);
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: nominal inference, both ack timeouts,
// spurious comp_done, abort during compute and asynchronous reset.
module tb_nn_layer_sequencer;

    logic       clk;
    logic       nrst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       comp_done;
    logic       get_image;
    logic       get_coeffs;
    logic [1:0] layer;
    logic       comp_start;
    logic       seq_busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    int total;
    int bad;
    int n_img;
    int n_coef;
    int n_comp;
    logic [3:0] coef_mask;

    nn_layer_sequencer #(
        .NUM_LAYERS  (3),
        .ACK_TIMEOUT (16),
        .TO_W        (5)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .comp_done  (comp_done),
        .get_image  (get_image),
        .get_coeffs (get_coeffs),
        .layer      (layer),
        .comp_start (comp_start),
        .seq_busy   (seq_busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after each, and tally pulses seen.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (get_image)  n_img++;
            if (get_coeffs) begin
                n_coef++;
                coef_mask = coef_mask | (4'b0001 << layer);
            end
            if (comp_start) n_comp++;
        end
    endtask

    // From a visible get_* pulse: busy rises one cycle later, stays 4 cycles, then falls.
    task automatic fetch_ack();
        step(1);
        busy = 1'b1;
        step(4);
        busy = 1'b0;
        step(1);
    endtask

    // From a visible get_coeffs for layer l: fetch, compute, comp_done 10 cycles after comp_start.
    task automatic run_layer(input logic [1:0] l);
        check_eq("coef_pulse", {31'd0, get_coeffs}, 32'd1);
        check_eq("coef_layer", {30'd0, layer}, {30'd0, l});
        fetch_ack();
        check_eq("comp_start", {31'd0, comp_start}, 32'd1);
        check_eq("comp_layer", {30'd0, layer}, {30'd0, l});
        step(9);
        comp_done = 1'b1;
        step(1);
        comp_done = 1'b0;
    endtask

    function automatic logic [31:0] outs_vec();
        return {23'd0, get_image, get_coeffs, layer, comp_start, seq_busy, done, error, err_code};
    endfunction

    initial begin
        int snap;
        total = 0; bad = 0; n_img = 0; n_coef = 0; n_comp = 0; coef_mask = 4'b0000;
        nrst = 1'b0; start = 1'b0; abort = 1'b0; busy = 1'b0; comp_done = 1'b0;
        #12;
        check_eq("reset_outs", outs_vec(), 32'd0);
        nrst = 1'b1;
        step(1);
        check_eq("idle_outs", outs_vec(), 32'd0);

        // Nominal three-layer inference
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_eq("nom_get_image", {31'd0, get_image}, 32'd1);
        check_eq("nom_seq_busy", {31'd0, seq_busy}, 32'd1);
        fetch_ack();
        run_layer(2'd0);
        run_layer(2'd1);
        run_layer(2'd2);
        check_eq("nom_done", {31'd0, done}, 32'd1);
        check_eq("nom_done_busy", {31'd0, seq_busy}, 32'd0);
        step(3);
        check_eq("nom_done_hold", {31'd0, done}, 32'd1);
        check_eq("nom_layer_hold", {30'd0, layer}, 32'd2);
        check_eq("nom_n_img", n_img, 32'd1);
        check_eq("nom_n_coef", n_coef, 32'd3);
        check_eq("nom_n_comp", n_comp, 32'd3);
        check_eq("nom_coef_mask", {28'd0, coef_mask}, 32'd7);

        // Image ack timeout: error exactly 16 cycles after entering ACK_IMG
        snap = n_coef;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_eq("ito_get_image", {31'd0, get_image}, 32'd1);
        check_eq("ito_layer_rst", {30'd0, layer}, 32'd0);
        step(1);
        step(15);
        check_eq("ito_not_yet", {31'd0, error}, 32'd0);
        check_eq("ito_busy_15", {31'd0, seq_busy}, 32'd1);
        step(1);
        check_eq("ito_error", {31'd0, error}, 32'd1);
        check_eq("ito_code", {30'd0, err_code}, 32'd1);
        check_eq("ito_no_coef", n_coef - snap, 32'd0);
        step(2);
        check_eq("ito_code_hold", {30'd0, err_code}, 32'd1);

        // Coeff ack timeout on layer 1, then restart from ERROR
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_eq("cto_restart_img", {31'd0, get_image}, 32'd1);
        check_eq("cto_err_clear", {29'd0, error, err_code}, 32'd0);
        fetch_ack();
        run_layer(2'd0);
        check_eq("cto_coef1", {29'd0, get_coeffs, layer}, 32'd5);
        step(1);
        step(16);
        check_eq("cto_error", {31'd0, error}, 32'd1);
        check_eq("cto_code", {30'd0, err_code}, 32'd2);
        check_eq("cto_layer", {30'd0, layer}, 32'd1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_eq("cto_clear", {29'd0, error, err_code}, 32'd0);
        check_eq("cto_get_image", {31'd0, get_image}, 32'd1);

        // Spurious comp_done during XFER_COEF on layer 0
        fetch_ack();
        check_eq("spd_coef0", {29'd0, get_coeffs, layer}, 32'd4);
        step(1);
        busy = 1'b1;
        step(1);
        comp_done = 1'b1;
        step(1);
        comp_done = 1'b0;
        busy = 1'b0;
        check_eq("spd_error", {31'd0, error}, 32'd1);
        check_eq("spd_code", {30'd0, err_code}, 32'd3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check_eq("spd_abort_idle", outs_vec(), 32'd0);
        comp_done = 1'b1;
        step(1);
        comp_done = 1'b0;
        step(1);
        check_eq("idle_comp_done", outs_vec(), 32'd0);

        // Abort while computing layer 2
        start = 1'b1;
        step(1);
        start = 1'b0;
        fetch_ack();
        run_layer(2'd0);
        run_layer(2'd1);
        fetch_ack();
        check_eq("abt_comp_start", {29'd0, comp_start, layer}, 32'd6);
        step(3);
        check_eq("abt_wait_busy", {31'd0, seq_busy}, 32'd1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check_eq("abt_idle", outs_vec(), 32'd0);
        snap = n_img + n_coef + n_comp;
        comp_done = 1'b1;
        step(1);
        comp_done = 1'b0;
        step(2);
        check_eq("abt_ignore_done", outs_vec(), 32'd0);
        check_eq("abt_no_pulses", n_img + n_coef + n_comp - snap, 32'd0);

        // Asynchronous reset during XFER_COEF on layer 1
        start = 1'b1;
        step(1);
        start = 1'b0;
        fetch_ack();
        run_layer(2'd0);
        step(1);
        busy = 1'b1;
        step(1);
        check_eq("ars_pre", {29'd0, seq_busy, layer}, 32'd5);
        #2;
        nrst = 1'b0;
        #1;
        check_eq("ars_outs_zero", outs_vec(), 32'd0);
        busy = 1'b0;
        #1;
        nrst = 1'b1;
        step(1);
        check_eq("ars_idle", outs_vec(), 32'd0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_eq("ars_get_image", {31'd0, get_image}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Top-level controller that sequences the NN datapath for one inference.
- Per inference: one image fetch (`get_image`), then for each layer a coefficient fetch (`get_coeffs` with `layer` selected) followed by a layer compute (`comp_start`/`comp_done`).
- Sits between the host-facing start/abort interface and the memory-fetch/compute datapath.
- Watches the fetch unit's `busy` handshake and times out on a missing acknowledge.

Parameters:
- NUM_LAYERS, 3: layers per inference, legal range 1..4. Layer index is 2 bits.
- ACK_TIMEOUT, 16: max cycles from a `get_*` pulse to `busy` rising before error.
- TO_W, 5: timeout counter width, must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- start  in  1  begin inference; sampled in IDLE, DONE, ERROR only
- abort  in  1  return to IDLE from any state at next edge
- busy  in  1  fetch unit busy (image or coeff transfer in progress)
- comp_done  in  1  one-cycle pulse from compute datapath, layer finished
- get_image  out  1  one-cycle pulse, request image fetch
- get_coeffs  out  1  one-cycle pulse, request coeff fetch for `layer`
- layer  out  2  current layer index, held stable from coeff request through compute
- comp_start  out  1  one-cycle pulse, start layer compute
- seq_busy  out  1  high in every state except IDLE, DONE, ERROR
- done  out  1  high while in DONE (inference complete)
- error  out  1  high while in ERROR
- err_code  out  2  00 none, 01 image ack timeout, 10 coeff ack timeout, 11 unexpected comp_done

Behaviour:
- Reset (nrst=0, async): state IDLE, all outputs 0, layer=0, timeout counter=0.
- All outputs are registered: each output reflects the state entered on the previous edge.
- IDLE: start=1 -> REQ_IMG.
- REQ_IMG: get_image=1 for exactly this cycle; clear counter; -> ACK_IMG.
- ACK_IMG:
  - busy=1 -> XFER_IMG.
  - Otherwise increment counter; counter reaching ACK_TIMEOUT -> ERROR with err_code=01.
- XFER_IMG: busy=0 -> REQ_COEF with layer=0.
- REQ_COEF: get_coeffs=1 for one cycle; clear counter; -> ACK_COEF.
- ACK_COEF: same rule as ACK_IMG; timeout sets err_code=10.
- XFER_COEF: busy=0 -> START_COMP.
- START_COMP: comp_start=1 for one cycle; -> WAIT_COMP.
- WAIT_COMP: comp_done=1 ->
  - layer==NUM_LAYERS-1: DONE.
  - Otherwise: layer+1, REQ_COEF.
- WAIT_COMP has no timeout.
- DONE: done=1; layer holds its last value; start=1 -> REQ_IMG with layer reset to 0.
- ERROR:
  - error=1; err_code holds.
  - start=1 clears err_code and error -> REQ_IMG.
  - abort=1 clears them -> IDLE.
- comp_done in any state other than WAIT_COMP, except IDLE/DONE/ERROR -> ERROR with err_code=11.
- comp_done in IDLE/DONE/ERROR is ignored.
- Priority in a given cycle: abort > comp_done error > timeout > normal transition.
- Abort from any state -> IDLE; layer=0; no further pulses are issued.
- Transfers already underway in the datapath are not cancelled by the sequencer.
- busy already high when entering ACK_*: counts as acknowledge on the first ACK cycle.
- start while seq_busy=1 is ignored.
- Latency with an immediate ack and a 1-cycle transfer:
  - start to get_image: 1 cycle.
  - busy falling to the next get_coeffs or comp_start: 1 cycle.

Decomposition:
- Package nn_pkg holds:
  - state enum seq_state_t (IDLE, REQ_IMG, ACK_IMG, XFER_IMG, REQ_COEF, ACK_COEF, XFER_COEF, START_COMP, WAIT_COMP, DONE, ERROR);
  - err_code_t constants ERR_NONE, ERR_IMG_TO, ERR_COEF_TO, ERR_SPUR_DONE;
  - localparam LAYER_W=2.
- One sub-module, ack_timer: a counter with clear, enable and a `expired` flag at ACK_TIMEOUT.
- Everything else is one FSM with registered outputs.

Test Plan:
- Nominal run, NUM_LAYERS=3: start pulse, busy high 1 cycle after each get_*, low 4 cycles later, comp_done 10 cycles after each comp_start -> expect:
  - 1 get_image, 3 get_coeffs with layer 0,1,2, 3 comp_start;
  - done=1 then stays 1 while layer=2.
- Image timeout: start, busy held 0 -> error=1 and err_code=01 exactly ACK_TIMEOUT=16 cycles after the ACK_IMG entry; no get_coeffs issued.
- Coeff timeout on layer 1: layer 0 completes normally, busy never rises after the second get_coeffs -> err_code=10, layer=1. Then start -> error clears, get_image seen 1 cycle later.
- Spurious done: comp_done pulse during XFER_COEF on layer 0 -> ERROR, err_code=11. Also: comp_done in IDLE -> no state change.
- Abort mid-compute: abort while in WAIT_COMP on layer 2 -> next cycle IDLE, seq_busy=0, layer=0; a later comp_done is ignored.
- Async reset mid-transfer: nrst low between clock edges during XFER_COEF -> all outputs 0 immediately. Then after release, start -> get_image 1 cycle later.
